// File: rtl/ssd_pkg.sv
// rtl/ssd_pkg.sv - shared constants and types for the seven-segment frame controller
package ssd_pkg;

   localparam int DATA_W               = 8;
   localparam int SEG_W                = 7;
   localparam int DIV_DEFAULT          = 50000;
   localparam int BLINK_FRAMES_DEFAULT = 250;

   typedef enum logic {
      REQ_A = 1'b0,
      REQ_B = 1'b1
   } req_idx_t;

endpackage

// File: rtl/ssd_tick_gen.sv
// rtl/ssd_tick_gen.sv - free-running prescaler producing a one-cycle strobe every DIV clocks
module ssd_tick_gen #(
   parameter int DIV = 50000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int               CNT_W    = $clog2(DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count <= '0;
      else if (count == CNT_LAST)
         count <= '0;
      else
         count <= count + 1'b1;
   end

   // Decoded from the counter alone, so it reads 0 as soon as reset clears the count.
   assign tick = (count == CNT_LAST);

endmodule

// File: rtl/ssd_frame_ctrl.sv
// rtl/ssd_frame_ctrl.sv - frame-synchronous two-requester display byte loader with blink/blank control
module ssd_frame_ctrl #(
   parameter int DIV          = ssd_pkg::DIV_DEFAULT,
   parameter int BLINK_FRAMES = ssd_pkg::BLINK_FRAMES_DEFAULT
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       req_a,
   input  logic [ssd_pkg::DATA_W-1:0] data_a,
   output logic                       gnt_a,
   input  logic                       req_b,
   input  logic [ssd_pkg::DATA_W-1:0] data_b,
   output logic                       gnt_b,
   input  logic                       blank,
   input  logic                       blink_en,
   output logic                       mux_tick,
   output logic [ssd_pkg::DATA_W-1:0] shown,
   output logic                       blank_o
);

   import ssd_pkg::*;

   localparam int              FC_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

   logic            phase;
   logic            frame_end;
   logic            win_a;
   logic            win_b;
   req_idx_t        last_grant;
   logic [FC_W-1:0] frame_cnt;
   logic            blink_phase;

   ssd_tick_gen #(.DIV(DIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (mux_tick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         phase <= 1'b0;
      else if (mux_tick)
         phase <= ~phase;
   end

   // A frame is two mux ticks; only its closing tick opens the request window.
   assign frame_end = mux_tick & phase;

   always_comb begin
      win_a = 1'b0;
      win_b = 1'b0;
      if (frame_end) begin
         if (req_a && (!req_b || last_grant == REQ_B))
            win_a = 1'b1;
         else if (req_b)
            win_b = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gnt_a      <= 1'b0;
         gnt_b      <= 1'b0;
         shown      <= '0;
         last_grant <= REQ_B;
      end else begin
         gnt_a <= win_a;
         gnt_b <= win_b;
         if (win_a) begin
            shown      <= data_a;
            last_grant <= REQ_A;
         end else if (win_b) begin
            shown      <= data_b;
            last_grant <= REQ_B;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (!blink_en) begin
         frame_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (frame_end) begin
         if (frame_cnt == FC_LAST) begin
            frame_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            frame_cnt <= frame_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         blank_o <= 1'b0;
      else
         blank_o <= blank | (blink_en & blink_phase);
   end

endmodule

// File: tb/tb_ssd_frame_ctrl.sv
// tb/tb_ssd_frame_ctrl.sv - directed checkpoint table plus randomized run against a frame-level model
module tb_ssd_frame_ctrl;

   localparam int DIV = 4;
   localparam int BF  = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_a = 1'b0, req_b = 1'b0;
   logic [7:0] data_a = 8'h00, data_b = 8'h00;
   logic       blank = 1'b0, blink_en = 1'b0;
   logic       gnt_a, gnt_b, mux_tick, blank_o;
   logic [7:0] shown;

   ssd_frame_ctrl #(.DIV(DIV), .BLINK_FRAMES(BF)) dut (
      .clk      (clk),
      .rst      (rst),
      .req_a    (req_a),
      .data_a   (data_a),
      .gnt_a    (gnt_a),
      .req_b    (req_b),
      .data_b   (data_b),
      .gnt_b    (gnt_b),
      .blank    (blank),
      .blink_en (blink_en),
      .mux_tick (mux_tick),
      .shown    (shown),
      .blank_o  (blank_o)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   int         m_n;
   bit         m_last;
   logic [7:0] m_shown;
   bit         m_ga, m_gb, m_bo;
   int         m_frames;

   typedef struct {
      int         scen;
      int         cyc;
      int         sel;
      logic [7:0] exp;
   } chk_t;
   chk_t tbl[$];

   function automatic void add(input int s, input int c, input int sel, input logic [7:0] e);
      chk_t r;
      r.scen = s; r.cyc = c; r.sel = sel; r.exp = e;
      tbl.push_back(r);
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%h want=%h", name, m_n, act, exp);
      end
   endtask

   function automatic void model_reset();
      m_n = 0; m_last = 1'b1; m_shown = 8'h00;
      m_ga = 0; m_gb = 0; m_bo = 0; m_frames = 0;
   endfunction

   // Frame position comes straight from the cycle count since release.
   function automatic void model_update();
      bit fe, bp, win;
      fe   = (m_n % (2 * DIV)) == (2 * DIV - 1);
      bp   = ((m_frames / BF) % 2) == 1;
      m_bo = blank | (blink_en & bp);
      m_ga = 0;
      m_gb = 0;
      if (fe && (req_a || req_b)) begin
         win = (req_a && req_b) ? !m_last : req_b;
         if (!win) begin m_ga = 1; m_shown = data_a; end
         else      begin m_gb = 1; m_shown = data_b; end
         m_last = win;
      end
      if (!blink_en) m_frames = 0;
      else if (fe)   m_frames++;
      m_n++;
   endfunction

   task automatic chk_zero(input string tag);
      chk({tag, "_mux_tick"}, {7'd0, mux_tick}, 8'h00);
      chk({tag, "_gnt_a"},    {7'd0, gnt_a},    8'h00);
      chk({tag, "_gnt_b"},    {7'd0, gnt_b},    8'h00);
      chk({tag, "_shown"},    shown,            8'h00);
      chk({tag, "_blank_o"},  {7'd0, blank_o},  8'h00);
   endtask

   // Entered at a negedge; reset is asserted mid-cycle to exercise the async path.
   task automatic pulse_reset();
      rst = 1'b1;
      #1;
      chk_zero("rst_async");
      @(posedge clk);
      @(negedge clk);
      chk_zero("rst_held");
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic tick_cycle(input int s);
      chk("mux_tick", {7'd0, mux_tick}, {7'd0, (m_n % DIV) == (DIV - 1)});
      chk("gnt_a",    {7'd0, gnt_a},    {7'd0, m_ga});
      chk("gnt_b",    {7'd0, gnt_b},    {7'd0, m_gb});
      chk("shown",    shown,            m_shown);
      chk("blank_o",  {7'd0, blank_o},  {7'd0, m_bo});
      foreach (tbl[i]) begin
         if (tbl[i].scen == s && tbl[i].cyc == m_n) begin
            case (tbl[i].sel)
               0:       chk("tbl_mux_tick", {7'd0, mux_tick}, tbl[i].exp);
               1:       chk("tbl_gnt_a",    {7'd0, gnt_a},    tbl[i].exp);
               2:       chk("tbl_gnt_b",    {7'd0, gnt_b},    tbl[i].exp);
               3:       chk("tbl_shown",    shown,            tbl[i].exp);
               default: chk("tbl_blank_o",  {7'd0, blank_o},  tbl[i].exp);
            endcase
         end
      end
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic set_inputs(input int s, input int c);
      req_a = 0; req_b = 0; data_a = 8'h00; data_b = 8'h00; blank = 0; blink_en = 0;
      case (s)
         1: begin req_a = (c <= 8); data_a = 8'h3C; end
         2: begin req_a = (c <= 8); req_b = (c <= 16); data_a = 8'h11; data_b = 8'h22; end
         3: begin req_a = 1; req_b = 1; data_a = 8'h11; data_b = 8'h22; end
         4: begin blink_en = (c < 50); blank = (c == 40 || c == 41); end
         5, 6: begin req_b = 1; data_b = 8'h5A; end
         default: ;
      endcase
   endtask

   initial begin
      // sel: 0 mux_tick, 1 gnt_a, 2 gnt_b, 3 shown, 4 blank_o
      add(0, 0, 0, 0);  add(0, 3, 0, 1);  add(0, 4, 0, 0);  add(0, 7, 0, 1);
      add(0, 11, 0, 1); add(0, 15, 0, 1); add(0, 20, 3, 8'h00);
      add(1, 7, 1, 0);  add(1, 8, 1, 1);  add(1, 8, 3, 8'h3C); add(1, 9, 1, 0);
      add(1, 9, 3, 8'h3C); add(1, 16, 1, 0); add(1, 16, 2, 0);
      add(2, 8, 1, 1);  add(2, 8, 3, 8'h11); add(2, 16, 2, 1); add(2, 16, 3, 8'h22);
      add(2, 17, 2, 0); add(2, 24, 1, 0);
      add(3, 8, 1, 1);  add(3, 8, 2, 0);  add(3, 16, 2, 1); add(3, 16, 1, 0);
      add(3, 24, 1, 1); add(3, 24, 3, 8'h11); add(3, 32, 2, 1); add(3, 32, 3, 8'h22);
      add(4, 16, 4, 0); add(4, 17, 4, 1); add(4, 32, 4, 1); add(4, 33, 4, 0);
      add(4, 41, 4, 1); add(4, 42, 4, 1); add(4, 43, 4, 0); add(4, 49, 4, 1);
      add(4, 50, 4, 1); add(4, 51, 4, 0);
      add(5, 3, 0, 1);  add(5, 5, 2, 0);
      add(6, 7, 2, 0);  add(6, 8, 2, 1);  add(6, 8, 3, 8'h5A); add(6, 9, 2, 0);

      model_reset();
      @(negedge clk);
      for (int s = 0; s < 7; s++) begin
         pulse_reset();
         for (int c = 0; c < ((s == 5) ? 6 : 60); c++) begin
            set_inputs(s, m_n);
            tick_cycle(s);
         end
      end

      set_inputs(7, 0);
      pulse_reset();
      for (int c = 0; c < 3000; c++) begin
         if (!req_a && $urandom_range(3) == 0) begin req_a = 1; data_a = 8'($urandom); end
         else if (req_a && (m_ga || $urandom_range(15) == 0)) req_a = 0;
         if (!req_b && $urandom_range(3) == 0) begin req_b = 1; data_b = 8'($urandom); end
         else if (req_b && (m_gb || $urandom_range(15) == 0)) req_b = 0;
         blank = ($urandom_range(15) == 0);
         if ($urandom_range(63) == 0) blink_en = ~blink_en;
         if ($urandom_range(499) == 0) pulse_reset();
         tick_cycle(7);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
